// File: rtl/traceback_unit.sv
// Traceback walker for the affine-gap local aligner. It reads the direction RAM
// from the best-score cell back to the local zero and streams M/I/D operations.
module traceback_unit #(
  parameter int ADDR_W    = 10,
  parameter int DIR_W     = 5,
  parameter int MAX_STEPS = 2048
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     max_row_i,
  input  logic [ADDR_W-1:0]     max_col_i,
  output logic                  dir_rd_en_o,
  output logic [2*ADDR_W-1:0]   dir_rd_addr_o,
  input  logic [DIR_W-1:0]      dir_rd_data_i,
  output logic                  op_valid_o,
  output logic [1:0]            op_o,
  input  logic                  op_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_W-1:0]     start_row_o,
  output logic [ADDR_W-1:0]     start_col_o,
  output logic [2:0]            dbg_state_o
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEPS);

  localparam logic [1:0] OP_M = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_D = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_LATCH = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    G_H  = 3'd0,
    G_F  = 3'd1,
    G_FH = 3'd2,
    G_E  = 3'd3,
    G_EH = 3'd4
  } gap_t;

  state_t              state_q, state_d;
  gap_t                gap_q, gap_d;
  logic [ADDR_W-1:0]   row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0]   srow_q, srow_d, scol_q, scol_d;
  logic [1:0]          op_q, op_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [STEP_W-1:0]   steps_q, steps_d;

  logic                is_diag, is_f, is_e, cont;
  logic [1:0]          dec_op;
  gap_t                dec_gap;
  logic                dec_zero;
  logic                mv_row, mv_col, hit_edge;
  logic [ADDR_W-1:0]   nrow, ncol;
  logic [STEP_W-1:0]   steps_inc;

  // Decode the word in the current gap state; a gap that does not continue
  // closes here and the same word is re-decoded as an H-state word.
  always_comb begin
    is_diag  = dir_rd_data_i[4];
    is_f     = (dir_rd_data_i == 5'b00111) || (dir_rd_data_i == 5'b01111);
    is_e     = (dir_rd_data_i == 5'b00011) || (dir_rd_data_i == 5'b01011);
    cont     = 1'b0;
    dec_op   = OP_M;
    dec_gap  = G_H;
    dec_zero = 1'b0;
    case (gap_q)
      G_F:     cont = (is_diag && dir_rd_data_i[3]) || is_f;
      G_FH:    cont = (is_diag && dir_rd_data_i[1]) || is_f;
      G_E:     cont = (is_diag && dir_rd_data_i[2]) || is_e;
      G_EH:    cont = (is_diag && dir_rd_data_i[0]) || is_e;
      default: cont = 1'b0;
    endcase
    if (cont) begin
      dec_gap = gap_q;
      dec_op  = ((gap_q == G_F) || (gap_q == G_FH)) ? OP_I : OP_D;
    end else if (is_diag) begin
      dec_op  = OP_M;
      dec_gap = G_H;
    end else if (is_f) begin
      dec_op  = OP_I;
      dec_gap = dir_rd_data_i[3] ? G_FH : G_F;
    end else if (is_e) begin
      dec_op  = OP_D;
      dec_gap = dir_rd_data_i[3] ? G_EH : G_E;
    end else begin
      dec_zero = 1'b1;
    end
  end

  // Moves saturate at 0; hitting the edge ends the walk after this op.
  always_comb begin
    mv_row   = (dec_op != OP_D);
    mv_col   = (dec_op != OP_I);
    hit_edge = (mv_row && (row_q == '0)) || (mv_col && (col_q == '0));
    nrow     = (mv_row && (row_q != '0)) ? row_q - 1'b1 : row_q;
    ncol     = (mv_col && (col_q != '0)) ? col_q - 1'b1 : col_q;
  end

  assign steps_inc = steps_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    row_d   = row_q;
    col_d   = col_q;
    srow_d  = srow_q;
    scol_d  = scol_q;
    op_d    = op_q;
    last_d  = last_q;
    err_d   = err_q;
    steps_d = steps_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          row_d   = max_row_i;
          col_d   = max_col_i;
          gap_d   = G_H;
          steps_d = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      S_ISSUE: state_d = S_LATCH;
      S_LATCH: begin
        srow_d = row_q;
        scol_d = col_q;
        gap_d  = dec_gap;
        if (dec_zero) begin
          state_d = S_DONE;
        end else begin
          op_d    = dec_op;
          row_d   = nrow;
          col_d   = ncol;
          last_d  = hit_edge;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (op_ready_i) begin
          steps_d = steps_inc;
          if (steps_inc >= MAX_S) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (last_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      gap_q   <= G_H;
      row_q   <= '0;
      col_q   <= '0;
      srow_q  <= '0;
      scol_q  <= '0;
      op_q    <= 2'b00;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      srow_q  <= srow_d;
      scol_q  <= scol_d;
      op_q    <= op_d;
      last_q  <= last_d;
      err_q   <= err_d;
      steps_q <= steps_d;
    end
  end

  // Stream handshake: op_o is held while op_valid_o && !op_ready_i; an op
  // transfers on a rising edge where both op_valid_o and op_ready_i are high.
  assign dir_rd_en_o   = (state_q == S_ISSUE);
  assign dir_rd_addr_o = {row_q, col_q};
  assign op_valid_o    = (state_q == S_EMIT);
  assign op_o          = op_q;
  assign busy_o        = (state_q == S_ISSUE) || (state_q == S_LATCH) || (state_q == S_EMIT);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;
  assign start_row_o   = srow_q;
  assign start_col_o   = scol_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: table of walks over a modelled direction RAM, with
// ops scored against an expected queue, plus backpressure and reset sequences.
module tb_traceback_unit;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic [9:0]  max_row_i = '0;
  logic [9:0]  max_col_i = '0;
  logic        dir_rd_en_o;
  logic [19:0] dir_rd_addr_o;
  logic [4:0]  dir_rd_data_i = '0;
  logic        op_valid_o;
  logic [1:0]  op_o;
  logic        op_ready_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [9:0]  start_row_o, start_col_o;
  logic [2:0]  dbg_state_o;

  traceback_unit #(.ADDR_W(10), .DIR_W(5), .MAX_STEPS(2048)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i),
    .max_row_i(max_row_i), .max_col_i(max_col_i),
    .dir_rd_en_o(dir_rd_en_o), .dir_rd_addr_o(dir_rd_addr_o),
    .dir_rd_data_i(dir_rd_data_i),
    .op_valid_o(op_valid_o), .op_o(op_o), .op_ready_i(op_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .start_row_o(start_row_o), .start_col_o(start_col_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] M = 2'b00, I = 2'b01, D = 2'b10;

  typedef struct {
    logic [9:0]       r, c;
    int               n_cells;
    logic [3:0][19:0] addr;
    logic [3:0][4:0]  dat;
    int               n_ops;
    logic [3:0][1:0]  ops;
    int               exp_done;
    logic [9:0]       exp_r, exp_c;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl[NV];

  logic [4:0] mem [int];
  logic [1:0] exp_q[$];
  int vec_cnt = 0;
  int miss = 0;
  int rdy_mode = 0;
  logic man_ready = 1'b0;

  function automatic void check(string name, int act, int exp);
    vec_cnt++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Direction RAM model: registered read, garbage when not strobed.
  always @(posedge clk) begin
    if (dir_rd_en_o)
      dir_rd_data_i <= mem.exists(int'(dir_rd_addr_o)) ? mem[int'(dir_rd_addr_o)] : 5'd0;
    else
      dir_rd_data_i <= 5'b10101;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       op_ready_i = 1'b1;
        1:       op_ready_i = 1'($urandom_range(0, 1));
        default: op_ready_i = man_ready;
      endcase
    end
  end

  // Scoreboard: every accepted op is popped and compared.
  always @(negedge clk) begin
    if (reset_i && op_valid_o && op_ready_i) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        miss++;
        $display("FAIL unexpected_op: got op %0d expected none", op_o);
      end else begin
        check("op", int'(op_o), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic set_case(int v, int r, int c, int done_cyc, int er, int ec);
    tbl[v].r = 10'(r);
    tbl[v].c = 10'(c);
    tbl[v].n_cells = 0;
    tbl[v].n_ops = 0;
    tbl[v].addr = '0;
    tbl[v].dat = '0;
    tbl[v].ops = '0;
    tbl[v].exp_done = done_cyc;
    tbl[v].exp_r = 10'(er);
    tbl[v].exp_c = 10'(ec);
  endtask

  task automatic add_cell(int v, int r, int c, logic [4:0] d);
    tbl[v].addr[tbl[v].n_cells] = {10'(r), 10'(c)};
    tbl[v].dat[tbl[v].n_cells] = d;
    tbl[v].n_cells++;
  endtask

  task automatic add_op(int v, logic [1:0] op);
    tbl[v].ops[tbl[v].n_ops] = op;
    tbl[v].n_ops++;
  endtask

  task automatic load_case(int v);
    mem.delete();
    for (int i = 0; i < tbl[v].n_cells; i++) mem[int'(tbl[v].addr[i])] = tbl[v].dat[i];
    for (int i = 0; i < tbl[v].n_ops; i++) exp_q.push_back(tbl[v].ops[i]);
  endtask

  task automatic start_walk(int v);
    @(posedge clk);
    #1;
    max_row_i = tbl[v].r;
    max_col_i = tbl[v].c;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(int v, bit timed);
    int cyc = 0;
    bit got = 0;
    while (cyc < 300 && !got) begin
      @(negedge clk);
      cyc++;
      if (done_o) got = 1;
    end
    check("done_seen", int'(got), 1);
    if (got) begin
      if (timed) check("done_cycle", cyc, tbl[v].exp_done);
      check("ops_left", exp_q.size(), 0);
      check("start_row", int'(start_row_o), int'(tbl[v].exp_r));
      check("start_col", int'(start_col_o), int'(tbl[v].exp_c));
      check("err_at_done", int'(err_o), 0);
      check("busy_at_done", int'(busy_o), 0);
      @(negedge clk);
      check("done_pulse", int'(done_o), 0);
    end
    exp_q.delete();
  endtask

  task automatic wait_valid(output bit got);
    int cyc = 0;
    got = 0;
    while (cyc < 50 && !got) begin
      @(negedge clk);
      cyc++;
      if (op_valid_o) got = 1;
    end
    check("valid_seen", int'(got), 1);
  endtask

  initial begin
    bit got;
    logic [1:0] first_op;

    set_case(0, 3, 3, 13, 0, 0);
    add_cell(0, 3, 3, 5'b10000); add_cell(0, 2, 2, 5'b10000);
    add_cell(0, 1, 1, 5'b10000); add_cell(0, 0, 0, 5'b10000);
    add_op(0, M); add_op(0, M); add_op(0, M); add_op(0, M);
    set_case(1, 5, 7, 3, 5, 7);
    add_cell(1, 5, 7, 5'b00000);
    set_case(2, 6, 4, 12, 3, 3);
    add_cell(2, 6, 4, 5'b00111); add_cell(2, 5, 4, 5'b11000);
    add_cell(2, 4, 4, 5'b10000); add_cell(2, 3, 3, 5'b00000);
    add_op(2, I); add_op(2, I); add_op(2, M);
    set_case(3, 2, 9, 12, 1, 6);
    add_cell(3, 2, 9, 5'b01011); add_cell(3, 2, 8, 5'b10001);
    add_cell(3, 2, 7, 5'b10000); add_cell(3, 1, 6, 5'b00000);
    add_op(3, D); add_op(3, D); add_op(3, M);
    set_case(4, 0, 5, 4, 0, 5);
    add_cell(4, 0, 5, 5'b00111);
    add_op(4, I);
    set_case(5, 4, 4, 12, 3, 2);
    add_cell(5, 4, 4, 5'b00111); add_cell(5, 3, 4, 5'b00011);
    add_cell(5, 3, 3, 5'b10100); add_cell(5, 3, 2, 5'b00000);
    add_op(5, I); add_op(5, D); add_op(5, D);
    set_case(6, 2, 2, 3, 2, 2);
    add_cell(6, 2, 2, 5'b00101);
    set_case(7, 1, 1, 7, 0, 0);
    add_cell(7, 1, 1, 5'b10000); add_cell(7, 0, 0, 5'b10000);
    add_op(7, M); add_op(7, M);
    set_case(8, 5, 5, 12, 2, 4);
    add_cell(8, 5, 5, 5'b01111); add_cell(8, 4, 5, 5'b10010);
    add_cell(8, 3, 5, 5'b10000); add_cell(8, 2, 4, 5'b00000);
    add_op(8, I); add_op(8, I); add_op(8, M);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_valid", int'(op_valid_o), 0);
    check("rst_rd_en", int'(dir_rd_en_o), 0);
    check("rst_addr", int'(dir_rd_addr_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_op", int'(op_o), 0);
    check("rst_srow", int'(start_row_o), 0);
    check("rst_scol", int'(start_col_o), 0);
    @(posedge clk);
    #1;
    reset_i = 1'b1;

    // Deterministic timing with ready held high
    rdy_mode = 0;
    for (int v = 0; v < NV; v++) begin
      load_case(v);
      start_walk(v);
      wait_done(v, 1'b1);
    end

    // Same walks under random backpressure
    rdy_mode = 1;
    for (int v = 0; v < NV; v++) begin
      load_case(v);
      start_walk(v);
      wait_done(v, 1'b0);
    end

    // Held-off first op must stay stable with no further reads
    rdy_mode = 2;
    man_ready = 1'b0;
    load_case(0);
    start_walk(0);
    wait_valid(got);
    first_op = op_o;
    check("bp_first_op", int'(first_op), int'(M));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", int'(op_valid_o), 1);
      check("bp_op_stable", int'(op_o), int'(first_op));
      check("bp_no_read", int'(dir_rd_en_o), 0);
    end
    man_ready = 1'b1;
    wait_done(0, 1'b0);

    // Reset in EMIT drops the pending op and gives no done
    man_ready = 1'b0;
    load_case(0);
    start_walk(0);
    wait_valid(got);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", int'(op_valid_o), 0);
    check("mid_rst_done", int'(done_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_rd_en", int'(dir_rd_en_o), 0);
    check("mid_rst_state", int'(dbg_state_o), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b1;
    rdy_mode = 0;
    load_case(7);
    start_walk(7);
    wait_done(7, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
    $finish;
  end

endmodule

// File: doc/traceback_unit.md
# traceback_unit

Walks the direction memory filled by the systolic PE array after a two-piece affine-gap local alignment. It starts at the best-score cell reported at the end of the PE chain and emits alignment operations from the end of the alignment back to its start over a ready/valid stream. It is the read-side counterpart of the PE direction write path and sits between the direction RAM and the CIGAR packer.

## Interface
- ADDR_W, 10: width of the row (query/PE index) and column (target) coordinates.
- DIR_W, 5: direction word width.
- MAX_STEPS, 2048: step budget before abort; must be ≥ 2^(ADDR_W+1).

- clk  in  1  clock.
- reset_i  in  1  reset. Asynchronous, active-low.
- start_i  in  1  one-cycle pulse; accepted only in IDLE.
- max_row_i  in  ADDR_W  row of the best-score cell, sampled on start.
- max_col_i  in  ADDR_W  column of the best-score cell, sampled on start.
- dir_rd_en_o  out  1  direction RAM read strobe.
- dir_rd_addr_o  out  2*ADDR_W  read address {row, col}.
- dir_rd_data_i  in  DIR_W  RAM data, valid exactly 1 cycle after dir_rd_en_o.
- op_valid_o  out  1  op available.
- op_o  out  2  00 = M (diagonal), 01 = I (row−1), 10 = D (col−1).
- op_ready_i  in  1  consumer accepts op.
- busy_o  out  1  high from the cycle after start until done.
- done_o  out  1  one-cycle pulse at completion.
- err_o  out  1  set with done_o on step-budget abort; cleared on next start.
- start_row_o, start_col_o  out  ADDR_W  last visited cell, valid from done_o until next start.

## Operation
- Direction word d:
  - d == 0: alignment start (local zero). Terminate.
  - d[4] = 1: diagonal. Extension bits: d[3] = F continues, d[2] = E continues, d[1] = F_hat continues, d[0] = E_hat continues.
  - Gap-entry codes: 00111 = F, 01111 = F_hat, 00011 = E, 01011 = E_hat.
  - Any other d[4] = 0 value: treat as 0.
- Gap state register: H, F, FH, E, EH. Cleared to H on start.
- FSM: IDLE → ISSUE → LATCH → EMIT → (ISSUE | DONE) → IDLE.
  - ISSUE: dir_rd_en_o = 1 for one cycle with the current {row, col}.
  - LATCH: decode dir_rd_data_i in the current gap state.
  - EMIT: hold op_valid_o/op_o until op_ready_i.
  - DONE: done_o = 1 for one cycle, then IDLE.
- Decode in state H:
  - Diagonal: op M; row−1, col−1; stay in H.
  - F or F_hat code: op I; row−1; state F or FH.
  - E or E_hat code: op D; col−1; state E or EH.
  - Zero: go to DONE, no op emitted.
- Decode in a gap state:
  - Diagonal word with the matching extension bit set, or an entry code of the same gap type: emit the same gap op, move again, keep the state.
  - Otherwise the gap opened here: set state H and decode the same word as H in the same LATCH cycle (no re-read).
  - Zero: DONE.
- Boundary: if a move would decrement a coordinate that is already 0, emit the op, then go to DONE instead of ISSUE. Coordinates never wrap.
- start_row_o/start_col_o hold the last cell read.
- Step counter increments per emitted op. Reaching MAX_STEPS aborts: finish the current handshake, then DONE with err_o = 1.
- start_i while busy is ignored.

## Timing
- Reset values: all outputs 0, FSM IDLE, gap state H, coordinates 0.
- start_i at cycle 0: ISSUE in cycle 1 (rd_en high); LATCH in cycle 2; op_valid_o high in cycle 3.
- With op_ready_i held high, throughput is 1 op per 3 cycles. The next ISSUE follows the handshake cycle.
- op_o is stable while op_valid_o && !op_ready_i.
- Zero word in LATCH at cycle n: done_o asserts at cycle n+1. busy_o drops in the same cycle.
- Boundary stop: done_o asserts the cycle after the final handshake.
- Reset mid-walk: immediate return to IDLE, any pending op dropped, no done_o.

## Test plan
- Diagonal path: start (3,3), cells (k,k) = 10000 for k = 3..0 → 4 × M, done_o in the cycle after the 4th handshake; start = (0,0); err_o = 0.
- Immediate stop: start (5,7), word 00000 → no op_valid_o; done_o at cycle 3; start_row_o = 5, start_col_o = 7.
- Extended insertion: (6,4) = 00111, (5,4) = 11000, (4,4) = 10000, (3,3) = 0 → I, I, M, then done; start = (3,3).
- Long deletion with open: (2,9) = 01011, (2,8) = 10001, (2,7) = 10000, (1,6) = 0 → D, D, M, done.
- Backpressure: op_ready_i low for 5 cycles during the first op → op_valid_o and op_o stable, no new read issued, op sequence unchanged.
- Reset asserted during EMIT, then a new start at (1,1) with (1,1) = (0,0) = 10000 → clean M, M, done with no residue from the aborted walk.
